// File: rtl/bp_network_pkg.sv
// Shared network helpers: flit/packet width arithmetic and the flit layout macro.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// The flit struct lives in a macro so the serializer and deserializer agree on
// field order ({dest, src, payload}, dest in the MSBs) from a single definition.
`ifndef BP_NETWORK_PKG_SV
`define BP_NETWORK_PKG_SV

`define BP_NETWORK_FLIT_S(dest_w, src_w, payload_w, struct_name) \
    typedef struct packed { \
        logic [(dest_w)-1:0]    dest; \
        logic [(src_w)-1:0]     src; \
        logic [(payload_w)-1:0] payload; \
    } struct_name

package bp_network_pkg;

    // clog2 that never returns 0, so one-entry ranges still get a 1-bit field
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // number of P-bit chunks needed to carry an S-bit message
    function automatic int num_packets(input int s, input int p);
        return (s + p - 1) / p;
    endfunction

    function automatic int flit_width(input int p, input int n_dest, input int n_src);
        return p + safe_clog2(n_dest) + safe_clog2(n_src);
    endfunction

endpackage

`endif

// File: rtl/bsg_dff_reset_en.sv
// Enabled register with synchronous active-high reset.
// Latency: 1 cycle from en_i to data_o.
// Backpressure: none; holds its value while en_i is low.
//
// Ports: clk_i, reset_i (sync, active-high), en_i load enable,
//        data_i next value, data_o registered value.
module bsg_dff_reset_en #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_o <= '0;
        end else if (en_i) begin
            data_o <= data_i;
        end
    end

endmodule

// File: rtl/bp_network_serializer.sv
// Splits one wide message into P-bit flits {dest, src, chunk}, lowest chunk first.
// Latency: flit 0 is valid the cycle after the accept; one flit per cycle after that.
// Backpressure: flits are held stable while ready_i is low; ready_o is low while a message is in flight.
//
// Ports: clk_i, reset_i (sync, active-high); message side v_i/ready_o/data_i/dest_id_i/src_id_i;
//        link side v_o/data_o/ready_i.
// Optional feature macro: BP_NETWORK_SERIALIZER_BACK_TO_BACK_EN lets a new message be
// accepted in the last-flit handshake cycle (no idle link cycle, but ready_i -> ready_o
// becomes a combinational path). Undefined by default.
module bp_network_serializer
    import bp_network_pkg::*;
#(
    parameter int num_dest            = 4,
    parameter int num_src             = 4,
    parameter int source_data_width_p = 40,
    parameter int packet_data_width_p = 16,
    localparam int dest_id_width_p    = safe_clog2(num_dest),
    localparam int src_id_width_p     = safe_clog2(num_src),
    localparam int num_packets_p      = num_packets(source_data_width_p, packet_data_width_p),
    localparam int total_o_data_width = flit_width(packet_data_width_p, num_dest, num_src)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           v_i,
    output logic                           ready_o,
    input  logic [source_data_width_p-1:0] data_i,
    input  logic [dest_id_width_p-1:0]     dest_id_i,
    input  logic [src_id_width_p-1:0]      src_id_i,
    output logic                           v_o,
    output logic [total_o_data_width-1:0]  data_o,
    input  logic                           ready_i
);

    localparam int msg_width_lp   = num_packets_p * packet_data_width_p;
    localparam int count_width_lp = safe_clog2(num_packets_p);
    localparam logic [count_width_lp-1:0] last_count_lp = count_width_lp'(num_packets_p - 1);

    `BP_NETWORK_FLIT_S(dest_id_width_p, src_id_width_p, packet_data_width_p, flit_s);

    typedef struct packed {
        logic [dest_id_width_p-1:0] dest;
        logic [src_id_width_p-1:0]  src;
        logic [msg_width_lp-1:0]    msg;
    } msg_s;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e                    state_r, state_n;
    logic [count_width_lp-1:0] count_r, count_n;
    logic                      last;
    logic                      accept;
    msg_s                      msg_in, msg_r;
    flit_s                     flit;

    // zero-extend so the unused top bits of the final chunk go out as zeros
    assign msg_in.dest = dest_id_i;
    assign msg_in.src  = src_id_i;
    assign msg_in.msg  = msg_width_lp'(data_i);

    assign last   = (count_r == last_count_lp);
    assign accept = v_i & ready_o;

    bsg_dff_reset_en #(
        .width_p ($bits(msg_s))
    ) msg_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (accept),
        .data_i  (msg_in),
        .data_o  (msg_r)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= IDLE;
            count_r <= '0;
        end else begin
            state_r <= state_n;
            count_r <= count_n;
        end
    end

    always_comb begin
        state_n = state_r;
        count_n = count_r;
        ready_o = 1'b0;
        v_o     = 1'b0;
        case (state_r)
            IDLE: begin
                ready_o = 1'b1;
                if (v_i) begin
                    state_n = SEND;
                    count_n = '0;
                end
            end
            SEND: begin
                v_o = 1'b1;
                if (ready_i) begin
                    if (last) begin
                        state_n = IDLE;
                        count_n = '0;
                    end else begin
                        count_n = count_r + count_width_lp'(1);
                    end
                end
`ifdef BP_NETWORK_SERIALIZER_BACK_TO_BACK_EN
                // reload straight from the last-flit handshake: stay in SEND at chunk 0
                ready_o = last & ready_i;
                if (last & ready_i & v_i) begin
                    state_n = SEND;
                    count_n = '0;
                end
`endif
            end
            default: begin
                state_n = IDLE;
                count_n = '0;
            end
        endcase
        // both handshakes are suppressed during reset; the register bank clears itself
        if (reset_i) begin
            ready_o = 1'b0;
            v_o     = 1'b0;
        end
    end

    assign flit.dest    = msg_r.dest;
    assign flit.src     = msg_r.src;
    assign flit.payload = msg_r.msg[count_r * packet_data_width_p +: packet_data_width_p];
    assign data_o       = flit;

endmodule
